// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one byte-wide RAM port between instruction fetch (IF)
// and the load/store stage (MEM). One whole transfer is granted at a time and
// serialised into byte cycles. Each transfer ends with a one-cycle done pulse
// and the assembled little-endian data.
//
// State table:
//   state  | meaning
//   IDLE   | no transfer; arbitrate between IF and MEM
//   RUN    | one byte address per cycle (write data for stores)
//   WAIT   | loads/fetches only: last read byte is on ram_data_in
//   DONE   | done pulse of the owner is high for this one cycle
//
// Ports:
//   clk_in, rst_in                  clock, synchronous active-high reset
//   flush_in                        cancel a pending or in-flight IF fetch
//   if_req_in/if_addr_in            fetch request (4 bytes)
//   if_done_out/if_inst_out         fetch done pulse and fetched word
//   mem_req_in/mem_rw_in/mem_addr_in/mem_len_in/mem_data_in
//                                   load/store request of 1, 2 or 4 bytes
//   mem_done_out/mem_data_out       load/store done pulse and load data
//   ram_rw_out/ram_addr_out/ram_data_out/ram_data_in
//                                   byte RAM port, read data one cycle late
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] if_inst_out,
    input  logic        mem_req_in,
    input  logic        mem_rw_in,
    input  logic [31:0] mem_addr_in,
    input  logic [2:0]  mem_len_in,
    input  logic [31:0] mem_data_in,
    output logic        mem_done_out,
    output logic [31:0] mem_data_out,
    output logic        ram_rw_out,
    output logic [31:0] ram_addr_out,
    output logic [7:0]  ram_data_out,
    input  logic [7:0]  ram_data_in
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic           own_mem_q;
    logic           rw_q;
    logic [31:0]    addr_q;
    logic [31:0]    data_q;      // store data, or read bytes assembled so far
    logic [1:0]     last_q;      // index of the final byte (len - 1)
    logic [1:0]     cnt_q;
    logic [SW-1:0]  starve_q;

    logic           if_elig;
    logic           grant_mem;
    logic           grant_if;
    logic           flush_if;
    logic           last_byte;
    logic [1:0]     req_last;
    logic [31:0]    rd_word;

    assign if_elig   = if_req_in & ~flush_in;
    assign grant_mem = mem_req_in & (~if_elig | (starve_q < STARVE_MAX));
    assign grant_if  = if_elig & ~grant_mem;
    assign flush_if  = flush_in & ~own_mem_q;
    assign last_byte = (cnt_q == last_q);
    assign req_last  = (mem_len_in == 3'd1) ? 2'd0 :
                       (mem_len_in == 3'd2) ? 2'd1 : 2'd3;

    // Final word: the last byte is still on ram_data_in during WAIT.
    always_comb begin
        rd_word = data_q;
        rd_word[{last_q, 3'b000} +: 8] = ram_data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            own_mem_q    <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            last_q       <= '0;
            cnt_q        <= '0;
            starve_q     <= '0;
            if_done_out  <= 1'b0;
            mem_done_out <= 1'b0;
            if_inst_out  <= '0;
            mem_data_out <= '0;
        end else begin
            state_q      <= state_d;
            if_done_out  <= 1'b0;
            mem_done_out <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (grant_mem) begin
                        own_mem_q <= 1'b1;
                        rw_q      <= mem_rw_in;
                        addr_q    <= mem_addr_in;
                        last_q    <= req_last;
                        data_q    <= mem_rw_in ? mem_data_in : 32'h0;
                        if (!if_elig)
                            starve_q <= '0;
                        else if (starve_q != STARVE_MAX)
                            starve_q <= starve_q + SW'(1);
                    end else if (grant_if) begin
                        own_mem_q <= 1'b0;
                        rw_q      <= 1'b0;
                        addr_q    <= if_addr_in;
                        last_q    <= 2'd3;
                        data_q    <= '0;
                        starve_q  <= '0;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + 2'd1;
                    // Byte addressed in the previous cycle is arriving now.
                    if (!rw_q && cnt_q != 2'd0)
                        data_q[{cnt_q - 2'd1, 3'b000} +: 8] <= ram_data_in;
                    if (last_byte && rw_q)
                        mem_done_out <= 1'b1;
                end
                S_WAIT: begin
                    if (!flush_if) begin
                        if (own_mem_q) begin
                            mem_done_out <= 1'b1;
                            mem_data_out <= rd_word;
                        end else begin
                            if_done_out <= 1'b1;
                            if_inst_out <= rd_word;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant_mem || grant_if) state_d = S_RUN;
            S_RUN: begin
                if (flush_if)
                    state_d = S_IDLE;
                else if (last_byte)
                    state_d = rw_q ? S_DONE : S_WAIT;
            end
            S_WAIT: state_d = flush_if ? S_IDLE : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_rw_out   = 1'b0;
        ram_addr_out = '0;
        ram_data_out = '0;
        if (state_q == S_RUN) begin
            ram_rw_out   = rw_q;
            ram_addr_out = addr_q + {30'b0, cnt_q};
            if (rw_q)
                ram_data_out = data_q[{cnt_q, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        flush_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_inst_out;
    logic        mem_req_in;
    logic        mem_rw_in;
    logic [31:0] mem_addr_in;
    logic [2:0]  mem_len_in;
    logic [31:0] mem_data_in;
    logic        mem_done_out;
    logic [31:0] mem_data_out;
    logic        ram_rw_out;
    logic [31:0] ram_addr_out;
    logic [7:0]  ram_data_out;
    logic [7:0]  ram_data_in;

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_inst_out(if_inst_out),
        .mem_req_in(mem_req_in), .mem_rw_in(mem_rw_in),
        .mem_addr_in(mem_addr_in), .mem_len_in(mem_len_in),
        .mem_data_in(mem_data_in), .mem_done_out(mem_done_out),
        .mem_data_out(mem_data_out), .ram_rw_out(ram_rw_out),
        .ram_addr_out(ram_addr_out), .ram_data_out(ram_data_out),
        .ram_data_in(ram_data_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          is_if;
        bit          chk_data;
        logic [31:0] data;
        int          exp_cyc;   // -1: cycle not checked
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  ram [0:4095];

    // Byte RAM: write on the edge, read data registered (one cycle late).
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (ram_rw_out) ram[ram_addr_out[11:0]] <= ram_data_out;
        ram_data_in <= ram[ram_addr_out[11:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the next expected transfer.
    always @(negedge clk_in) begin
        if (if_done_out || mem_done_out) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got if=%0b mem=%0b expected no done (cycle %0d)",
                         if_done_out, mem_done_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_both", {31'b0, if_done_out & mem_done_out}, 32'h0);
                chk("done_kind_if", {31'b0, if_done_out}, {31'b0, mon_e.is_if});
                if (mon_e.chk_data)
                    chk("done_data", mon_e.is_if ? if_inst_out : mem_data_out, mon_e.data);
                if (mon_e.exp_cyc >= 0)
                    chk("done_cycle", cyc, mon_e.exp_cyc);
            end
        end
    end

    // Called on a negedge while the arbiter is idle-bound; gdelay = extra
    // edges before the grant can happen.
    task automatic issue_if(input logic [31:0] a, input logic [31:0] exp);
        exp_t e;
        if_req_in  = 1'b1;
        if_addr_in = a;
        e.is_if = 1'b1; e.chk_data = 1'b1; e.data = exp; e.exp_cyc = cyc + 1 + 5;
        sb.push_back(e);
    endtask

    task automatic issue_mem(input logic rw, input logic [31:0] a, input logic [2:0] len,
                             input logic [31:0] d, input logic [31:0] exp, input int gdelay);
        exp_t e;
        int   nb;
        nb = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
        mem_req_in  = 1'b1;
        mem_rw_in   = rw;
        mem_addr_in = a;
        mem_len_in  = len;
        mem_data_in = d;
        e.is_if = 1'b0; e.chk_data = !rw; e.data = exp;
        e.exp_cyc = cyc + 1 + gdelay + (rw ? nb : nb + 1);
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk_in);
            #1;
            n++;
            if (if_done_out || mem_done_out) begin
                seen = 1'b1;
                if_req_in  = 1'b0;
                mem_req_in = 1'b0;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done in 60 cycles expected a done pulse");
            if_req_in  = 1'b0;
            mem_req_in = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_done"},  {31'b0, if_done_out}, 32'h0);
        chk({tag, "_mem_done"}, {31'b0, mem_done_out}, 32'h0);
        chk({tag, "_if_inst"},  if_inst_out, 32'h0);
        chk({tag, "_mem_data"}, mem_data_out, 32'h0);
        chk({tag, "_ram_rw"},   {31'b0, ram_rw_out}, 32'h0);
        chk({tag, "_ram_addr"}, ram_addr_out, 32'h0);
        chk({tag, "_ram_wdata"}, {24'b0, ram_data_out}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sd;
        int          n;
        exp_t        e;

        rst_in = 1'b1; flush_in = 1'b0;
        if_req_in = 1'b0; if_addr_in = '0;
        mem_req_in = 1'b0; mem_rw_in = 1'b0; mem_addr_in = '0;
        mem_len_in = '0; mem_data_in = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
        ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
        ram[12'h200] = 8'hFF; ram[12'h201] = 8'h80;

        repeat (3) @(negedge clk_in);
        chk_all_zero("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        // IF fetch: addresses 0x100..0x103 on consecutive cycles
        issue_if(32'h100, 32'h0010_0513);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk("fetch_addr", ram_addr_out, 32'h100 + k);
            chk("fetch_rw", {31'b0, ram_rw_out}, 32'h0);
        end
        wait_done();
        @(negedge clk_in);

        // MEM loads of 2, 1 and an out-of-range length (treated as 4)
        issue_mem(1'b0, 32'h200, 3'd2, 32'h0, 32'h0000_80FF, 0);
        wait_done();
        @(negedge clk_in);
        issue_mem(1'b0, 32'h200, 3'd1, 32'h0, 32'h0000_00FF, 0);
        wait_done();
        @(negedge clk_in);
        issue_mem(1'b0, 32'h100, 3'd3, 32'h0, 32'h0010_0513, 0);
        wait_done();
        @(negedge clk_in);

        // MEM store of 4 bytes
        sd = 32'hDEAD_BEEF;
        issue_mem(1'b1, 32'h300, 3'd4, sd, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk("store_rw", {31'b0, ram_rw_out}, 32'h1);
            chk("store_addr", ram_addr_out, 32'h300 + k);
            chk("store_byte", {24'b0, ram_data_out}, {24'b0, sd[8*k +: 8]});
        end
        wait_done();
        @(negedge clk_in);
        chk("store_rw_after", {31'b0, ram_rw_out}, 32'h0);
        chk("store_ram", {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]}, 32'hDEAD_BEEF);

        // Both requests held: four MEM grants, then IF, repeated
        for (int i = 0; i < 10; i++) begin
            e.is_if = ((i % 5) == 4);
            e.chk_data = 1'b1;
            e.data = e.is_if ? 32'h0010_0513 : 32'h0000_80FF;
            e.exp_cyc = -1;
            sb.push_back(e);
        end
        mem_rw_in = 1'b0; mem_addr_in = 32'h200; mem_len_in = 3'd2;
        if_addr_in = 32'h100;
        mem_req_in = 1'b1; if_req_in = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk_in);
            #2;
            n++;
        end
        mem_req_in = 1'b0; if_req_in = 1'b0;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL starve_timeout: got %0d transfers left expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk_in);

        // Flush on the second RUN cycle of a fetch; pending MEM wins next
        if_req_in = 1'b1; if_addr_in = 32'h100;
        @(negedge clk_in);
        @(negedge clk_in);
        flush_in = 1'b1;
        issue_mem(1'b0, 32'h200, 3'd1, 32'h0, 32'h0000_00FF, 1);
        @(negedge clk_in);
        chk("flush_idle_addr", ram_addr_out, 32'h0);
        chk("flush_inst_held", if_inst_out, 32'h0010_0513);
        flush_in = 1'b0; if_req_in = 1'b0;
        wait_done();
        @(negedge clk_in);

        // Reset in the middle of a store (cnt = 1)
        mem_req_in = 1'b1; mem_rw_in = 1'b1; mem_addr_in = 32'h300;
        mem_len_in = 3'd4; mem_data_in = 32'h1122_3344;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rst_store_addr", ram_addr_out, 32'h301);
        rst_in = 1'b1; mem_req_in = 1'b0;
        @(negedge clk_in);
        chk_all_zero("midrst");
        rst_in = 1'b0;
        @(negedge clk_in);
        issue_mem(1'b0, 32'h300, 3'd2, 32'h0, 32'h0000_3344, 0);
        wait_done();

        repeat (4) @(negedge clk_in);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover: got %0d pending transfers expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequencing arbiter between the IF stage and the MEM stage for the single byte-wide RAM port.
- Grants one whole transfer at a time: an IF word fetch (4 bytes), or a MEM load/store of 1, 2 or 4 bytes.
- Serialises the transfer into byte cycles and returns a one-cycle done pulse with assembled data.
- Bounds IF starvation under continuous MEM traffic; supports flushing an in-flight IF fetch on redirect.

Parameters:
STARVE_LIMIT, 4, max consecutive MEM grants while if_req_in is pending before IF is forced to win (>=1)

Ports:
clk_in  in  1  clock, all state updates on posedge
rst_in  in  1  synchronous reset, active-high
flush_in  in  1  cancel the pending or in-flight IF fetch
if_req_in  in  1  IF fetch request, held until if_done_out seen
if_addr_in  in  32  IF fetch byte address
if_done_out  out  1  one-cycle pulse, fetch complete
if_inst_out  out  32  fetched word, valid while if_done_out=1
mem_req_in  in  1  MEM request, held until mem_done_out seen
mem_rw_in  in  1  0=load, 1=store
mem_addr_in  in  32  MEM byte address
mem_len_in  in  3  bytes: 1, 2 or 4; any other value is treated as 4
mem_data_in  in  32  store data, little-endian, low bytes used
mem_done_out  out  1  one-cycle pulse, load/store complete
mem_data_out  out  32  load data, zero-extended, valid while mem_done_out=1
ram_rw_out  out  1  0=read, 1=write
ram_addr_out  out  32  RAM byte address
ram_data_out  out  8  RAM write byte
ram_data_in  in  8  RAM read byte, valid the cycle after the address cycle

Behaviour:
- Reset: state IDLE, cnt=0, starve_cnt=0. Outputs: if_done_out=0, mem_done_out=0, if_inst_out=0, mem_data_out=0, ram_rw_out=0, ram_addr_out=0, ram_data_out=0.
- Reset mid-transfer aborts the transfer with no done pulse; partially written bytes remain in RAM.
- States: IDLE, RUN, WAIT, DONE.
- IDLE:
  - ram_rw_out=0, ram_addr_out=0.
  - IF is eligible only if if_req_in=1 and flush_in=0.
  - Grant MEM if mem_req_in=1 and (IF not eligible or starve_cnt<STARVE_LIMIT); else grant IF if eligible.
  - On grant, latch owner, addr, rw, len (IF: read, len 4), store data; cnt<=0; go to RUN.
- starve_cnt: updated only on grant edges.
  - MEM grant with IF eligible: starve_cnt+1, saturating at STARVE_LIMIT.
  - IF grant: reset to 0.
  - MEM grant with IF not eligible: reset to 0.
- RUN:
  - ram_addr_out=addr+cnt (32-bit wrap); cnt increments each edge.
  - Store: ram_rw_out=1, ram_data_out=data byte[cnt].
  - Load/fetch: ram_rw_out=0, ram_data_out=0.
  - At the edge with cnt=len-1: store goes to DONE with mem_done_out<=1; load/fetch goes to WAIT.
- Read capture: the byte for addr+i is on ram_data_in the cycle after it is addressed and is captured at the following edge.
- WAIT:
  - ram_rw_out=0, ram_addr_out=0.
  - ram_data_in carries the last byte.
  - At the next edge, the done output and data output of the owner are registered, with the last byte taken directly from ram_data_in; go to DONE.
- DONE:
  - done pulse high for exactly one cycle; data output holds its value.
  - Next state is IDLE.
  - The requester must drop its req during DONE; a req still high in the following IDLE is a new request.
- Latency, counted in edges after the grant edge: load/fetch of L bytes, done visible after L+1 edges; store, after L edges. Back-to-back transfers have one IDLE cycle between them.
- Flush:
  - In IDLE, blocks an IF grant on that edge.
  - In RUN/WAIT with owner IF, the next state is IDLE with no if_done_out and if_inst_out unchanged.
  - In DONE, no effect.
  - Never affects MEM transfers.
- Simultaneous mem_req/if_req: arbitration as above. A request arriving during RUN/WAIT/DONE waits for IDLE.

Test Plan:
- Reset, then if_req_in=1, if_addr_in=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_addr_out 0x100..0x103 on consecutive cycles; if_done_out one cycle at grant+5 edges; if_inst_out=0x00100513.
- MEM load len=2, addr=0x200, bytes 0xFF,0x80 -> mem_data_out=0x000080FF, mem_done_out pulse at grant+3; len=1 -> 0x000000FF at grant+2.
- MEM store len=4, addr=0x300, data=0xDEADBEEF -> ram_rw_out=1 for 4 cycles, writing EF,BE,AD,DE to 0x300..0x303; mem_done_out at grant+4; ram_rw_out=0 afterwards.
- mem_req_in and if_req_in held continuously, STARVE_LIMIT=4 -> grant order MEM,MEM,MEM,MEM,IF,MEM...; IF is never starved beyond 4 MEM transfers.
- flush_in pulsed on the 2nd RUN cycle of an IF fetch -> no if_done_out; state IDLE next edge; a pending mem_req_in is granted on the following edge.
- rst_in asserted mid-store (cnt=1) -> all outputs 0 on the next edge, no mem_done_out; a new request is accepted after rst_in deasserts.
